// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial double-dabble binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam int unsigned MAX_DIGITS = 16;

    // All-nines pattern covering exactly `digits` digits: the largest value below 10^digits.
    function automatic logic [4*MAX_DIGITS-1:0] sat_pattern(input int unsigned digits);
        logic [4*MAX_DIGITS-1:0] pat;
        pat = '0;
        for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
            if (d < digits) begin
                pat[4*d +: 4] = BCD_NINE;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One double-dabble digit step: add 3 when the digit is 5 or more, then shift left
// with carry-in.
module bcd_digit_cell (
    input  logic [3:0] digit_i,
    input  logic       carry_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] adj;

    always_comb begin
        adj     = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
        digit_o = {adj[2:0], carry_i};
        carry_o = adj[3];
    end

endmodule

// File: rtl/bcd_serial_converter.sv
// Iterative binary-to-BCD converter that takes one input bit per clock. It has a
// valid/ready handshake, overflow saturation and a leading-zero blanking mask.
module bcd_serial_converter
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 16,
    parameter int unsigned DIGITS    = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_WIDTH-1:0]  binary_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [4*MAX_DIGITS-1:0] SAT_FULL = sat_pattern(DIGITS);
    localparam logic [4*DIGITS-1:0] SAT = SAT_FULL[4*DIGITS-1:0];

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]   shreg_q, shreg_d;
    logic [4*DIGITS-1:0]    digits_q, digits_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]      blank_q, blank_d;
    logic                   ovf_q, ovf_d;
    logic                   out_valid_q, out_valid_d;

    logic [4*DIGITS-1:0]    shifted;
    logic [DIGITS:0]        carry;
    logic [DIGITS-1:0]      blank_fin;
    logic                   zero_above;
    logic                   fin_ovf;

    // The binary MSB feeds the ones digit; each digit's bit3 feeds the next one up.
    assign carry[0] = shreg_q[BIN_WIDTH-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_digit_cell u_cell (
            .digit_i (digits_q[4*g +: 4]),
            .carry_i (carry[g]),
            .digit_o (shifted[4*g +: 4]),
            .carry_o (carry[g+1])
        );
    end

    // Anything shifted out of the top digit means the value needs more digits.
    assign fin_ovf = ovf_acc_q | carry[DIGITS];

    always_comb begin
        blank_fin  = '0;
        zero_above = 1'b1;
        for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
            zero_above   = zero_above && (shifted[4*d +: 4] == 4'd0);
            blank_fin[d] = zero_above;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        digits_d    = digits_q;
        ovf_acc_d   = ovf_acc_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d   = binary_in;
                    digits_d  = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_INIT;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shreg_d   = {shreg_q[BIN_WIDTH-2:0], 1'b0};
                digits_d  = shifted;
                ovf_acc_d = fin_ovf;
                cnt_d     = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = StDone;
                    bcd_d   = fin_ovf ? SAT : shifted;
                    blank_d = fin_ovf ? '0 : blank_fin;
                    ovf_d   = fin_ovf;
                end
            end
            StDone: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            digits_q    <= '0;
            ovf_acc_q   <= 1'b0;
            bcd_q       <= '0;
            blank_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            digits_q    <= digits_d;
            ovf_acc_q   <= ovf_acc_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = out_valid_q;
    assign bcd_out    = bcd_q;
    assign blank_mask = blank_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Bench for bcd_serial_converter: four width/digit configurations checked against a decimal model.
`timescale 1ns/1ps
module tb_bcd_serial_converter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // 0: 16b/5d  1: 16b/4d  2: 8b/3d  3: 20b/7d
    logic        iv0, iv1, iv2, iv3;
    logic        or0, or1, or2, or3;
    logic [15:0] bi0, bi1;
    logic [7:0]  bi2;
    logic [19:0] bi3;
    logic        ir0, ir1, ir2, ir3;
    logic        ov0, ov1, ov2, ov3;
    logic        of0, of1, of2, of3;
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;
    logic [27:0] bcd3;
    logic [4:0]  bm0;
    logic [3:0]  bm1;
    logic [2:0]  bm2;
    logic [6:0]  bm3;

    int n_pass = 0;
    int n_total = 0;

    bcd_serial_converter #(.BIN_WIDTH(16), .DIGITS(5)) u_d0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0), .binary_in(bi0),
        .out_valid(ov0), .out_ready(or0), .bcd_out(bcd0), .blank_mask(bm0), .overflow(of0));
    bcd_serial_converter #(.BIN_WIDTH(16), .DIGITS(4)) u_d1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .binary_in(bi1),
        .out_valid(ov1), .out_ready(or1), .bcd_out(bcd1), .blank_mask(bm1), .overflow(of1));
    bcd_serial_converter #(.BIN_WIDTH(8), .DIGITS(3)) u_d2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2), .binary_in(bi2),
        .out_valid(ov2), .out_ready(or2), .bcd_out(bcd2), .blank_mask(bm2), .overflow(of2));
    bcd_serial_converter #(.BIN_WIDTH(20), .DIGITS(7)) u_d3 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv3), .in_ready(ir3), .binary_in(bi3),
        .out_valid(ov3), .out_ready(or3), .bcd_out(bcd3), .blank_mask(bm3), .overflow(of3));

    function automatic int bw_of(input int id);
        case (id)
            0, 1:    return 16;
            2:       return 8;
            default: return 20;
        endcase
    endfunction

    function automatic int dg_of(input int id);
        case (id)
            0:       return 5;
            1:       return 4;
            2:       return 3;
            default: return 7;
        endcase
    endfunction

    // Decimal reference: digits by repeated division, blanking from the decimal length.
    function automatic void model(input int digits, input logic [19:0] v,
                                  output logic [27:0] bcd, output logic [6:0] bm,
                                  output logic of);
        longint unsigned lim, t, x;
        int nd;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        t   = longint'(v);
        of  = (t >= lim);
        nd  = 1;
        x   = t / 10;
        while (x != 0) begin
            nd++;
            x = x / 10;
        end
        bcd = '0;
        bm  = '0;
        for (int d = 0; d < digits; d++) begin
            bcd[4*d +: 4] = of ? 4'd9 : 4'(t % 10);
            t = t / 10;
            bm[d] = !of && (d >= nd);
        end
    endfunction

    task automatic put(input int id, input logic vld, input logic [19:0] v, input logic rdy);
        case (id)
            0:       begin iv0 = vld; bi0 = v[15:0]; or0 = rdy; end
            1:       begin iv1 = vld; bi1 = v[15:0]; or1 = rdy; end
            2:       begin iv2 = vld; bi2 = v[7:0];  or2 = rdy; end
            default: begin iv3 = vld; bi3 = v;       or3 = rdy; end
        endcase
    endtask

    task automatic get(input int id, output logic ir, output logic ov,
                       output logic [27:0] bcd, output logic [6:0] bm, output logic of);
        case (id)
            0:       begin ir = ir0; ov = ov0; bcd = {8'd0, bcd0};  bm = {2'd0, bm0}; of = of0; end
            1:       begin ir = ir1; ov = ov1; bcd = {12'd0, bcd1}; bm = {3'd0, bm1}; of = of1; end
            2:       begin ir = ir2; ov = ov2; bcd = {16'd0, bcd2}; bm = {4'd0, bm2}; of = of2; end
            default: begin ir = ir3; ov = ov3; bcd = bcd3;          bm = bm3;         of = of3; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Full handshake with out_ready held high; checks latency, result and return to idle.
    task automatic convert(input int id, input logic [19:0] v, input string tag);
        logic ir, ov, of, eof;
        logic [27:0] bcd, ebcd;
        logic [6:0] bm, ebm;
        int n;
        model(dg_of(id), v, ebcd, ebm, eof);
        put(id, 1'b1, v, 1'b1);
        @(posedge clk); #1;
        put(id, 1'b0, v, 1'b1);
        n = 0;
        get(id, ir, ov, bcd, bm, of);
        while (!ov && n < 60) begin
            @(posedge clk); #1;
            n++;
            get(id, ir, ov, bcd, bm, of);
        end
        check({tag, "_valid"}, 32'(ov), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(bw_of(id) + 1));
        check({tag, "_bcd"}, {4'd0, bcd}, {4'd0, ebcd});
        check({tag, "_blank"}, {25'd0, bm}, {25'd0, ebm});
        check({tag, "_ovf"}, 32'(of), 32'(eof));
        @(posedge clk); #1;
        get(id, ir, ov, bcd, bm, of);
        check({tag, "_consumed"}, {30'd0, ov, ir}, 32'b01);
    endtask

    initial begin
        logic ir, ov, of, eof;
        logic [27:0] bcd, ebcd;
        logic [6:0] bm, ebm;
        logic [19:0] r;
        int n;

        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) put(i, 1'b0, 20'd0, 1'b0);
        #12;
        get(0, ir, ov, bcd, bm, of);
        check("rst_in_ready", 32'(ir), 32'd1);
        check("rst_out_valid", 32'(ov), 32'd0);
        check("rst_bcd", {4'd0, bcd}, 32'd0);
        check("rst_blank", {25'd0, bm}, 32'd0);
        check("rst_ovf", 32'(of), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        convert(0, 20'd1234, "d1234");
        convert(0, 20'd0, "zero");
        convert(0, 20'hFFFF, "ffff");
        convert(1, 20'd12345, "ovf12345");
        convert(1, 20'd9999, "nine9999");
        convert(1, 20'd10000, "ovf10000");

        // Back-pressure: result must hold while out_ready is low; a new in_valid is dropped.
        model(5, 20'd5678, ebcd, ebm, eof);
        put(0, 1'b1, 20'd5678, 1'b0);
        @(posedge clk); #1;
        put(0, 1'b0, 20'd5678, 1'b0);
        n = 0;
        get(0, ir, ov, bcd, bm, of);
        while (!ov && n < 60) begin
            @(posedge clk); #1;
            n++;
            get(0, ir, ov, bcd, bm, of);
        end
        check("bp_valid", 32'(ov), 32'd1);
        for (int i = 0; i < 10; i++) begin
            put(0, (i == 3), 20'd999, 1'b0);
            @(posedge clk); #1;
            get(0, ir, ov, bcd, bm, of);
            check("bp_hold", {ov, ir, of, bm[4:0], bcd[19:0]},
                  {1'b1, 1'b0, eof, ebm[4:0], ebcd[19:0]});
        end
        put(0, 1'b0, 20'd0, 1'b1);
        @(posedge clk); #1;
        get(0, ir, ov, bcd, bm, of);
        check("bp_release", {30'd0, ov, ir}, 32'b01);
        convert(0, 20'd31415, "bp_next");

        // Asynchronous reset during the 7th shift cycle.
        put(0, 1'b1, 20'd777, 1'b1);
        @(posedge clk); #1;
        put(0, 1'b0, 20'd777, 1'b1);
        repeat (6) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        get(0, ir, ov, bcd, bm, of);
        check("arst_outputs", {ov, of, bm[4:0], bcd[19:0]}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        get(0, ir, ov, bcd, bm, of);
        check("arst_idle", {30'd0, ov, ir}, 32'b01);
        convert(0, 20'd42, "after_rst");

        // Randomised sweeps, including the extremes of each width.
        convert(2, 20'd0, "w8_min");
        convert(2, 20'd255, "w8_max");
        convert(3, 20'd0, "w20_min");
        convert(3, 20'hFFFFF, "w20_max");
        for (int i = 0; i < 300; i++) begin
            r = 20'($urandom_range(0, 255));
            convert(2, r, "rnd_w8");
        end
        for (int i = 0; i < 300; i++) begin
            r = 20'($urandom_range(0, 65535));
            convert(0, r, "rnd_w16");
        end
        for (int i = 0; i < 300; i++) begin
            r = 20'($urandom_range(0, 1048575));
            convert(3, r, "rnd_w20");
        end
        for (int i = 0; i < 200; i++) begin
            r = 20'($urandom_range(0, 65535));
            convert(1, r, "rnd_w16d4");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
